// File: rtl/dcache_tag_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dcache_tag_array: set-associative dcache tag store, registered lookup,   |
// | fill/mark-dirty updates, valid sweep after reset. Optional flush via the |
// | DCACHE_TAG_FLUSH_EN macro.                       Revision: 1.0           |
// +--------------------------------------------------------------------------+
module dcache_tag_array #(
  parameter int TAG_W   = 22,
  parameter int INDEX_W = 5,
  parameter int WAYS    = 2,
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               ready_o,
  input  logic               lkp_i,
  input  logic [INDEX_W-1:0] lkp_index_i,
  input  logic [TAG_W-1:0]   lkp_tag_i,
  output logic               res_valid_o,
  output logic               hit_o,
  output logic [WAY_W-1:0]   hit_way_o,
  output logic [WAY_W-1:0]   vic_way_o,
  output logic               vic_valid_o,
  output logic               vic_dirty_o,
  output logic [TAG_W-1:0]   vic_tag_o,
  input  logic               wr_i,
  input  logic               wr_fill_i,
  input  logic [INDEX_W-1:0] wr_index_i,
  input  logic [WAY_W-1:0]   wr_way_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic               wr_dirty_i,
  input  logic               flush_i
);

  localparam int                 SETS     = 1 << INDEX_W;
  localparam logic [WAY_W-1:0]   WAY_MASK = WAY_W'(WAYS - 1);
  localparam logic [INDEX_W-1:0] LAST_SET = INDEX_W'(SETS - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [INDEX_W-1:0] sweep_cnt;

  logic [TAG_W-1:0]   tag_mem   [SETS][WAYS];
  logic [WAYS-1:0]    valid_mem [SETS];
  logic [WAYS-1:0]    dirty_mem [SETS];
  logic [WAY_W-1:0]   ptr_mem   [SETS];

  logic               flush_go;
  logic               accept;
  logic               lkp_go;
  logic               wr_go;

`ifdef DCACHE_TAG_FLUSH_EN
  assign flush_go = (state == ST_IDLE) && rst_i && flush_i;
`else
  logic unused_flush;
  assign unused_flush = flush_i;
  assign flush_go     = 1'b0;
`endif

  // A flush in the same cycle swallows any lookup or write.
  assign accept  = (state == ST_IDLE) && rst_i && !flush_go;
  assign lkp_go  = accept && lkp_i;
  assign wr_go   = accept && wr_i;
  assign ready_o = (state == ST_IDLE);

  // ---------------------------------------------------------------- lookup
  logic [WAYS-1:0]  set_valid;
  logic [WAYS-1:0]  set_dirty;
  logic [WAYS-1:0]  tag_match;
  logic             hit_c;
  logic [WAY_W-1:0] hit_way_c;
  logic [WAY_W-1:0] vic_way_c;

  assign set_valid = valid_mem[lkp_index_i];
  assign set_dirty = dirty_mem[lkp_index_i];

  generate
    for (genvar w = 0; w < WAYS; w++) begin : g_cmp
      assign tag_match[w] = set_valid[w] && (tag_mem[lkp_index_i][w] == lkp_tag_i);
    end
  endgenerate

  always_comb begin
    hit_c     = |tag_match;
    hit_way_c = '0;
    vic_way_c = ptr_mem[lkp_index_i];
    // Descending scan so the lowest-numbered candidate is the one kept.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (tag_match[w]) begin
        hit_way_c = WAY_W'(w);
      end
      if (!set_valid[w]) begin
        vic_way_c = WAY_W'(w);
      end
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: begin
        if (sweep_cnt == LAST_SET) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (flush_go) begin
          state_nxt = ST_INIT;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // ------------------------------------------------- line state and sweep
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sweep_cnt <= '0;
    end else if (state == ST_INIT) begin
      sweep_cnt            <= sweep_cnt + INDEX_W'(1);
      valid_mem[sweep_cnt] <= '0;
      dirty_mem[sweep_cnt] <= '0;
      ptr_mem[sweep_cnt]   <= '0;
    end else begin
      if (flush_go) begin
        sweep_cnt <= '0;
      end
      if (wr_go) begin
        if (wr_fill_i) begin
          valid_mem[wr_index_i][wr_way_i] <= 1'b1;
          dirty_mem[wr_index_i][wr_way_i] <= wr_dirty_i;
          // Round-robin only moves when the fill displaces a valid line.
          if (&valid_mem[wr_index_i]) begin
            ptr_mem[wr_index_i] <= (ptr_mem[wr_index_i] + WAY_W'(1)) & WAY_MASK;
          end
        end else if (valid_mem[wr_index_i][wr_way_i]) begin
          dirty_mem[wr_index_i][wr_way_i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_go && wr_fill_i) begin
      tag_mem[wr_index_i][wr_way_i] <= wr_tag_i;
    end
  end

  // ---------------------------------------------------------- result regs
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      res_valid_o <= 1'b0;
      hit_o       <= 1'b0;
      hit_way_o   <= '0;
      vic_way_o   <= '0;
      vic_valid_o <= 1'b0;
      vic_dirty_o <= 1'b0;
      vic_tag_o   <= '0;
    end else begin
      res_valid_o <= lkp_go;
      if (lkp_go) begin
        hit_o       <= hit_c;
        hit_way_o   <= hit_way_c;
        vic_way_o   <= vic_way_c;
        vic_valid_o <= set_valid[vic_way_c];
        vic_dirty_o <= set_dirty[vic_way_c];
        vic_tag_o   <= tag_mem[lkp_index_i][vic_way_c];
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/dcache_tag_array.md
# dcache_tag_array

Parametrised set-associative tag store for the data cache, generalising the single-way 32-entry tag SRAM to WAYS ways × 2^INDEX_W sets with per-line valid/dirty state. It performs a registered tag compare and reports hit way and replacement victim. It also executes fill and mark-dirty updates, and self-clears all valid bits after reset. It sits between the dcache controller FSM and the data SRAM, supplying hit/victim decisions one cycle after a lookup.

## Interface
- TAG_W, 22, tag bits stored per line.
- INDEX_W, 5, set index bits; SETS = 2^INDEX_W.
- WAYS, 2, associativity; power of two, 1..8; WAY_W = max(1, log2(WAYS)).
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- ready_o  out  1  high when idle and accepting requests.
- lkp_i  in  1  lookup request, sampled when ready_o=1.
- lkp_index_i  in  INDEX_W  lookup set.
- lkp_tag_i  in  TAG_W  lookup tag.
- res_valid_o  out  1  lookup result valid, one cycle after an accepted lkp_i.
- hit_o  out  1  tag matched a valid way.
- hit_way_o  out  WAY_W  matching way; 0 on miss.
- vic_way_o  out  WAY_W  replacement victim for the looked-up set.
- vic_valid_o, vic_dirty_o  out  1 each  victim line state.
- vic_tag_o  out  TAG_W  victim tag, for write-back address.
- wr_i  in  1  update request, sampled when ready_o=1.
- wr_fill_i  in  1  1 = fill (install tag), 0 = mark dirty.
- wr_index_i  in  INDEX_W; wr_way_i  in  WAY_W; wr_tag_i  in  TAG_W; wr_dirty_i  in  1  update target and data.
- flush_i  in  1  invalidate-all request (see Configuration).

## Operation
- States: INIT, IDLE. Reset (rst_i=0) enters INIT with sweep counter 0. All outputs are 0 during and after reset, including ready_o and res_valid_o.
- INIT: each cycle clears valid, dirty and the round-robin pointer of set[counter] in all ways, then increments the counter. After set SETS-1 is cleared, the state goes to IDLE. INIT lasts exactly SETS cycles. ready_o=0 throughout, and lkp_i and wr_i are ignored.
- IDLE: ready_o=1. lkp_i and wr_i may both assert in the same cycle.
- Lookup: compare lkp_tag_i against all valid ways of the set. At most one way matches; hit_way_o is the lowest matching way.
- Victim selection: the lowest-numbered invalid way if any exists. Otherwise the set's round-robin pointer.
- Fill (wr_fill_i=1): way[wr_way_i] of the set gets tag=wr_tag_i, valid=1, dirty=wr_dirty_i. If every way of the set was valid before the fill, the pointer advances by 1 mod WAYS.
- Mark dirty (wr_fill_i=0): sets dirty=1 on the way if it is valid. Tag and pointer are unchanged. It is a no-op on an invalid way.
- Simultaneous lookup and write to the same set: the lookup sees pre-write state (read-before-write). The controller sequences a re-lookup if it needs post-write state.
- Reset mid-operation: discards any pending result (res_valid_o=0 next cycle) and restarts INIT from set 0.

## Timing
- Lookup latency is 1. lkp_i accepted at edge N gives res_valid_o=1 and all result fields valid in the cycle after N, for exactly one cycle.
- Result fields hold their last value while res_valid_o=0.
- Write effect is visible to a lookup accepted at the next edge.
- Throughput: one lookup plus one write per cycle in IDLE.
- Post-reset: ready_o rises SETS cycles after the first edge with rst_i=1.

## Configuration
- DCACHE_TAG_FLUSH_EN defined: flush_i accepted in IDLE re-enters INIT. This takes SETS cycles, with ready_o=0, and clears all lines without write-back. flush_i has priority over a same-cycle lkp_i/wr_i: those are dropped, and res_valid_o stays 0.
- Not defined: flush_i is ignored, and the FSM enters INIT only on reset.

## Test plan
- Reset with rst_i=0 for 3 cycles, then release. Required: ready_o=0 for 32 cycles, then 1. A lookup of any set/tag gives hit_o=0, vic_way_o=0, vic_valid_o=0.
- Fill set 5 way 0 with tag 0x12345 (dirty=0), then look up set 5 tag 0x12345. Required: res_valid_o=1 one cycle later, hit_o=1, hit_way_o=0. A lookup of tag 0x12346 gives hit_o=0, vic_way_o=1, vic_valid_o=0.
- Fill set 7 ways 0 and 1 with tags 0xA and 0xB, then look up a miss. Required: vic_way_o=0. After a refill of way 0 with 0xC, a miss lookup gives vic_way_o=1, vic_tag_o=0xB.
- Mark-dirty set 7 way 1, then look up a miss. Required: vic_way_o=1, vic_dirty_o=1, vic_valid_o=1.
- Same-cycle lookup and fill of set 3 tag 0x7. Required: hit_o=0 for that lookup; the next lookup gives hit_o=1.
- With DCACHE_TAG_FLUSH_EN, pulse flush_i after filling sets 0 and 31. Required: ready_o=0 for 32 cycles, and subsequent lookups miss with vic_valid_o=0. Without the macro, the same flush_i pulse leaves ready_o=1 and both lines still hit.
